// File: rtl/audio_stream_pwm.sv
// Audio sample streamer: a FIFO is filled by the SD loader and drained one frame
// of interleaved channels per sample period. Each sample is volume-scaled and
// drives a per-channel PWM output whose duty updates only at period boundaries.
module audio_stream_pwm #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 1024,
   parameter int CHANNELS   = 2,
   parameter int SAMPLE_DIV = 2268,
   parameter int PWM_W      = 8,
   parameter int VOL_W      = 4
) (
   input  logic                            Clk,
   input  logic                            reset_rtl_0_n,
   input  logic                            wr_en,
   input  logic [DATA_W-1:0]               wr_data,
   input  logic                            enable_audio,
   input  logic                            flush,
   input  logic [VOL_W-1:0]                volume,
   output logic                            full,
   output logic [$clog2(FIFO_DEPTH):0]     level,
   output logic                            overflow,
   output logic                            underrun,
   output logic [15:0]                     underrun_count,
   output logic                            frame_tick,
   output logic [CHANNELS-1:0]             AUDIO_PWM
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int PW = DATA_W + VOL_W + 1;
   localparam logic [PWM_W-1:0] MID = PWM_W'(1 << (PWM_W - 1));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;
   localparam logic [1:0] S_LOAD  = 2'd3;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic          underrun_q, underrun_d;
   logic [15:0]   urun_cnt_q, urun_cnt_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
   logic [CHANNELS-1:0][DATA_W-1:0] samp_q, samp_d;
   logic [CHANNELS-1:0][PWM_W-1:0]  pend_q, pend_d, act_q, act_d;

   logic full_w, push, pop, frame_due;

   // Sample scaled by (volume+1)/2^VOL_W, then its top PWM_W bits in offset binary.
   function automatic logic [PWM_W-1:0] duty_of(input logic [DATA_W-1:0] s,
                                                input logic [VOL_W-1:0] v);
      logic signed [PW-1:0] se, g, p, sc;
      logic [PW-1:0] off;
      se  = {{(VOL_W+1){s[DATA_W-1]}}, s};
      g   = signed'(PW'({1'b0, v}) + PW'(1));
      p   = se * g;
      sc  = p >>> VOL_W;
      off = unsigned'(sc) + PW'(1 << (DATA_W - 1));
      return PWM_W'(off >> (DATA_W - PWM_W));
   endfunction

   // FIFO handshake, frame timer and pointer bookkeeping; flush wins over everything.
   always_comb begin
      full_w    = (level_q == LW'(FIFO_DEPTH));
      push      = wr_en && !full_w && !flush;
      pop       = (state_q == S_FETCH) && !flush;
      frame_due = enable_audio && (state_q == S_WAIT) && (timer_q == TW'(SAMPLE_DIV - 1));
      wr_ptr_d  = wr_ptr_q + AW'(push);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      level_d   = level_q + LW'(push) - LW'(pop);
      timer_d   = timer_q;
      if (enable_audio)
         timer_d = (timer_q == TW'(SAMPLE_DIV - 1)) ? '0 : timer_q + TW'(1);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         timer_d  = '0;
      end
   end

   // Frame sequencer: wait for the sample period, fetch one word per channel, load duties.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      samp_d     = samp_q;
      pend_d     = pend_q;
      underrun_d = 1'b0;
      urun_cnt_d = urun_cnt_q;
      overflow_d = overflow_q || (wr_en && full_w);
      case (state_q)
         S_IDLE: if (enable_audio) state_d = S_WAIT;
         S_WAIT: begin
            if (!enable_audio) state_d = S_IDLE;
            else if (frame_due) begin
               if (level_q >= LW'(CHANNELS)) begin
                  state_d = S_FETCH;
                  ch_d    = '0;
               end else begin
                  // Short frame: keep the previous samples playing.
                  underrun_d = 1'b1;
                  if (urun_cnt_q != 16'hFFFF) urun_cnt_d = urun_cnt_q + 16'd1;
               end
            end
         end
         // Runs to completion regardless of enable so channels stay aligned.
         S_FETCH: begin
            samp_d[ch_q] = mem[rd_ptr_q];
            if (ch_q == CW'(CHANNELS - 1)) begin
               state_d = S_LOAD;
               ch_d    = '0;
            end else begin
               ch_d = ch_q + CW'(1);
            end
         end
         default: begin
            for (int c = 0; c < CHANNELS; c++) pend_d[c] = duty_of(samp_q[c], volume);
            state_d = enable_audio ? S_WAIT : S_IDLE;
         end
      endcase
      if (flush) begin
         state_d    = S_IDLE;
         ch_d       = '0;
         pend_d     = {CHANNELS{MID}};
         overflow_d = 1'b0;
         urun_cnt_d = '0;
         underrun_d = 1'b0;
      end
   end

   // PWM: free-running counter, duty latched at the wrap so each period is glitch-free.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      act_d     = (pwm_cnt_q == '1) ? pend_q : act_q;
      if (flush) act_d = {CHANNELS{MID}};
      for (int c = 0; c < CHANNELS; c++)
         pwm_out_d[c] = enable_audio && (pwm_cnt_q < act_q[c]);
   end

   // Sample storage; contents need no reset since level gates every read.
   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   // State registers.
   always_ff @(posedge Clk or negedge reset_rtl_0_n) begin
      if (!reset_rtl_0_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         timer_q    <= '0;
         state_q    <= S_IDLE;
         ch_q       <= '0;
         underrun_q <= 1'b0;
         urun_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         pwm_out_q  <= '0;
         samp_q     <= '0;
         pend_q     <= {CHANNELS{MID}};
         act_q      <= {CHANNELS{MID}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         timer_q    <= timer_d;
         state_q    <= state_d;
         ch_q       <= ch_d;
         underrun_q <= underrun_d;
         urun_cnt_q <= urun_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         pwm_out_q  <= pwm_out_d;
         samp_q     <= samp_d;
         pend_q     <= pend_d;
         act_q      <= act_d;
      end
   end

   assign full           = full_w;
   assign level          = level_q;
   assign overflow       = overflow_q;
   assign underrun       = underrun_q;
   assign underrun_count = urun_cnt_q;
   assign frame_tick     = (state_q == S_FETCH) && (ch_q == '0);
   assign AUDIO_PWM      = pwm_out_q;

endmodule

// File: tb/tb_audio_stream_pwm.sv
// Bench for audio_stream_pwm at default parameters: FIFO, frame timing,
// scaling, underrun, pause, flush and asynchronous reset.
module tb_audio_stream_pwm;
   localparam int DATA_W = 16, FIFO_DEPTH = 1024, CHANNELS = 2;
   localparam int SAMPLE_DIV = 2268, PWM_W = 8, VOL_W = 4;

   logic Clk = 1'b0;
   logic reset_rtl_0_n = 1'b1;
   logic wr_en = 1'b0, enable_audio = 1'b0, flush = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic [VOL_W-1:0] volume = '1;
   logic full, overflow, underrun, frame_tick;
   logic [$clog2(FIFO_DEPTH):0] level;
   logic [15:0] underrun_count;
   logic [CHANNELS-1:0] AUDIO_PWM;

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [15:0] model_q[$];

   audio_stream_pwm #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CHANNELS(CHANNELS),
      .SAMPLE_DIV(SAMPLE_DIV), .PWM_W(PWM_W), .VOL_W(VOL_W)) dut (
      .Clk(Clk), .reset_rtl_0_n(reset_rtl_0_n), .wr_en(wr_en), .wr_data(wr_data),
      .enable_audio(enable_audio), .flush(flush), .volume(volume), .full(full),
      .level(level), .overflow(overflow), .underrun(underrun),
      .underrun_count(underrun_count), .frame_tick(frame_tick), .AUDIO_PWM(AUDIO_PWM));

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Expected duty: floor(sample*(vol+1)/16) moved to offset binary, top 8 bits.
   function automatic int model_duty(input logic [15:0] w, input int vol);
      int s, scaled;
      s = int'($signed(w));
      scaled = (s * (vol + 1)) >>> VOL_W;
      return (scaled + 32768) / 256;
   endfunction

   task automatic write_word(input logic [15:0] w);
      wr_en = 1'b1; wr_data = w;
      @(negedge Clk);
      wr_en = 1'b0;
      model_q.push_back(w);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge Clk);
      flush = 1'b0;
      model_q.delete();
   endtask

   task automatic wait_evt(input bit sel_urun, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge Clk);
         if ((sel_urun ? underrun : frame_tick) === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic measure(output int h0, output int h1);
      h0 = 0; h1 = 0;
      repeat (1 << PWM_W) begin
         @(negedge Clk);
         h0 += int'(AUDIO_PWM[0]);
         h1 += int'(AUDIO_PWM[1]);
      end
   endtask

   task automatic test_reset();
      #3 reset_rtl_0_n = 1'b0;
      #1;
      n_chk++; if ({full, overflow, underrun, frame_tick} !== 4'b0) begin n_fail++;
         $display("FAIL reset_flags: got %b expected 0000", {full, overflow, underrun, frame_tick}); end
      n_chk++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      repeat (3) @(negedge Clk);
      n_chk++; if ({underrun_count, AUDIO_PWM} !== '0) begin n_fail++;
         $display("FAIL reset_cnt_pwm: got %h expected 0", {underrun_count, AUDIO_PWM}); end
      reset_rtl_0_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_playback();
      int t0, h0, h1, vol;
      bit ok;
      do_flush();
      volume = 4'd15; vol = 15;
      write_word(16'h7FFF); write_word(16'h8000); write_word(16'h0000); write_word(16'h4000);
      write_word(16'($urandom)); write_word(16'($urandom));
      enable_audio = 1'b1; t0 = cyc;
      for (int f = 0; f < 3; f++) begin
         logic [15:0] w0, w1;
         wait_evt(1'b0, SAMPLE_DIV + 10, ok);
         n_chk++; if (!ok || cyc - t0 != SAMPLE_DIV * (f + 1)) begin n_fail++;
            $display("FAIL play_tick_time f%0d: got %0d expected %0d", f, cyc - t0, SAMPLE_DIV * (f + 1)); end
         w0 = model_q.pop_front(); w1 = model_q.pop_front();
         repeat (300) @(negedge Clk);
         n_chk++; if (level !== 11'(model_q.size())) begin n_fail++;
            $display("FAIL play_level f%0d: got %0d expected %0d", f, level, model_q.size()); end
         measure(h0, h1);
         n_chk++; if (h0 != model_duty(w0, vol) || h1 != model_duty(w1, vol)) begin n_fail++;
            $display("FAIL play_duty f%0d: got %0d/%0d expected %0d/%0d", f, h0, h1,
                     model_duty(w0, vol), model_duty(w1, vol)); end
         vol = $urandom_range(0, 15); volume = 4'(vol);
      end
      enable_audio = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_volume();
      int h0, h1;
      bit ok;
      do_flush();
      write_word(16'h7FFF); write_word(16'h7FFF); write_word(16'h7FFF); write_word(16'h7FFF);
      volume = 4'd7; enable_audio = 1'b1;
      wait_evt(1'b0, SAMPLE_DIV + 10, ok);
      repeat (300) @(negedge Clk);
      measure(h0, h1);
      n_chk++; if (!ok || h0 != 191 || h1 != 191) begin n_fail++;
         $display("FAIL vol7_duty: got %0d/%0d expected 191/191", h0, h1); end
      volume = 4'd0;
      wait_evt(1'b0, SAMPLE_DIV + 10, ok);
      repeat (300) @(negedge Clk);
      measure(h0, h1);
      n_chk++; if (!ok || h0 != 135 || h1 != 135) begin n_fail++;
         $display("FAIL vol0_duty: got %0d/%0d expected 135/135", h0, h1); end
      enable_audio = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_underrun();
      int t0, h0, h1;
      bit ok;
      do_flush();
      volume = '1;
      write_word(16'($urandom));
      enable_audio = 1'b1; t0 = cyc;
      wait_evt(1'b1, SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || cyc - t0 != SAMPLE_DIV) begin n_fail++;
         $display("FAIL urun_time: got %0d expected %0d", cyc - t0, SAMPLE_DIV); end
      n_chk++; if (underrun_count !== 16'd1 || level !== 11'd1) begin n_fail++;
         $display("FAIL urun_state: got cnt %0d lvl %0d expected 1/1", underrun_count, level); end
      @(negedge Clk);
      n_chk++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL urun_pulse: got %b expected 0", underrun); end
      repeat (300) @(negedge Clk);
      measure(h0, h1);
      n_chk++; if (h0 != 128 || h1 != 128) begin n_fail++;
         $display("FAIL urun_duty: got %0d/%0d expected 128/128", h0, h1); end
      wait_evt(1'b1, SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || cyc - t0 != 2 * SAMPLE_DIV || underrun_count !== 16'd2) begin n_fail++;
         $display("FAIL urun_second: got t %0d cnt %0d expected %0d/2", cyc - t0, underrun_count, 2 * SAMPLE_DIV); end
      enable_audio = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_fifo_full();
      bit ok;
      int need;
      need = FIFO_DEPTH - model_q.size();
      wr_en = 1'b1;
      for (int i = 0; i < need; i++) begin
         wr_data = 16'($urandom);
         @(negedge Clk);
         model_q.push_back(wr_data);
         if (i == need - 2) begin
            n_chk++; if (full !== 1'b0 || level !== 11'(FIFO_DEPTH - 1)) begin n_fail++;
               $display("FAIL almost_full: got full %b lvl %0d expected 0/%0d", full, level, FIFO_DEPTH - 1); end
         end
      end
      n_chk++; if (full !== 1'b1 || overflow !== 1'b0) begin n_fail++;
         $display("FAIL full_set: got full %b ovf %b expected 1/0", full, overflow); end
      @(negedge Clk);
      n_chk++; if (overflow !== 1'b1 || level !== 11'(FIFO_DEPTH)) begin n_fail++;
         $display("FAIL overflow: got ovf %b lvl %0d expected 1/%0d", overflow, level, FIFO_DEPTH); end
      enable_audio = 1'b1;
      wait_evt(1'b0, 2 * SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || level !== 11'(FIFO_DEPTH)) begin n_fail++;
         $display("FAIL full_tick: got ok %b lvl %0d expected 1/%0d", ok, level, FIFO_DEPTH); end
      @(negedge Clk);
      n_chk++; if (level !== 11'(FIFO_DEPTH - 1)) begin n_fail++;
         $display("FAIL pop_at_full: got %0d expected %0d", level, FIFO_DEPTH - 1); end
      @(negedge Clk);
      n_chk++; if (level !== 11'(FIFO_DEPTH - 1)) begin n_fail++;
         $display("FAIL push_pop: got %0d expected %0d", level, FIFO_DEPTH - 1); end
      @(negedge Clk);
      n_chk++; if (level !== 11'(FIFO_DEPTH)) begin n_fail++;
         $display("FAIL refill: got %0d expected %0d", level, FIFO_DEPTH); end
      enable_audio = 1'b0; wr_en = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_flush();
      int t0, h0, h1;
      bit ok;
      enable_audio = 1'b1; wr_en = 1'b1; wr_data = 16'h1234; flush = 1'b1; t0 = cyc;
      @(negedge Clk);
      flush = 1'b0; wr_en = 1'b0; model_q.delete();
      n_chk++; if (level !== '0 || full !== 1'b0 || overflow !== 1'b0 || underrun_count !== '0) begin n_fail++;
         $display("FAIL flush_clear: got lvl %0d full %b ovf %b cnt %0d expected 0", level, full, overflow, underrun_count); end
      repeat (300) @(negedge Clk);
      measure(h0, h1);
      n_chk++; if (h0 != 128 || h1 != 128) begin n_fail++;
         $display("FAIL flush_duty: got %0d/%0d expected 128/128", h0, h1); end
      wait_evt(1'b1, SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || cyc - t0 != SAMPLE_DIV + 1 || underrun_count !== 16'd1) begin n_fail++;
         $display("FAIL flush_timer: got t %0d cnt %0d expected %0d/1", cyc - t0, underrun_count, SAMPLE_DIV + 1); end
      enable_audio = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_pause();
      int t1, k, h0, h1;
      bit ok;
      logic [15:0] w0, w1;
      do_flush();
      volume = 4'($urandom_range(0, 15));
      write_word(16'($urandom)); write_word(16'($urandom));
      k = $urandom_range(200, 1500);
      enable_audio = 1'b1;
      repeat (k) @(negedge Clk);
      enable_audio = 1'b0;
      repeat (100) @(negedge Clk);
      n_chk++; if (AUDIO_PWM !== '0) begin n_fail++; $display("FAIL pause_pwm: got %b expected 00", AUDIO_PWM); end
      enable_audio = 1'b1; t1 = cyc;
      wait_evt(1'b0, SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || cyc - t1 != SAMPLE_DIV - k) begin n_fail++;
         $display("FAIL pause_hold: got %0d expected %0d", cyc - t1, SAMPLE_DIV - k); end
      enable_audio = 1'b0;
      w0 = model_q.pop_front(); w1 = model_q.pop_front();
      @(negedge Clk);
      n_chk++; if (level !== 11'd1) begin n_fail++; $display("FAIL drop_fetch1: got %0d expected 1", level); end
      repeat (6) @(negedge Clk);
      n_chk++; if (level !== '0 || AUDIO_PWM !== '0) begin n_fail++;
         $display("FAIL drop_done: got lvl %0d pwm %b expected 0/00", level, AUDIO_PWM); end
      write_word(16'($urandom)); write_word(16'($urandom));
      enable_audio = 1'b1; t1 = cyc;
      repeat (300) @(negedge Clk);
      measure(h0, h1);
      n_chk++; if (h0 != model_duty(w0, int'(volume)) || h1 != model_duty(w1, int'(volume))) begin n_fail++;
         $display("FAIL drop_duty: got %0d/%0d expected %0d/%0d", h0, h1,
                  model_duty(w0, int'(volume)), model_duty(w1, int'(volume))); end
      wait_evt(1'b0, SAMPLE_DIV + 10, ok);
      n_chk++; if (!ok || cyc - t1 != SAMPLE_DIV) begin n_fail++;
         $display("FAIL drop_restart: got %0d expected %0d", cyc - t1, SAMPLE_DIV); end
      enable_audio = 1'b0;
      repeat (6) @(negedge Clk);
   endtask

   task automatic test_async_reset();
      bit ok;
      do_flush();
      write_word(16'($urandom)); write_word(16'($urandom));
      enable_audio = 1'b1;
      wait_evt(1'b0, SAMPLE_DIV + 10, ok);
      #2 reset_rtl_0_n = 1'b0;
      #1;
      n_chk++; if (!ok || {full, overflow, underrun, frame_tick, underrun_count, AUDIO_PWM} !== '0 || level !== '0) begin
         n_fail++; $display("FAIL async_reset: got ok %b tick %b lvl %0d pwm %b expected 1/0/0/00",
                            ok, frame_tick, level, AUDIO_PWM); end
      enable_audio = 1'b0;
      @(negedge Clk);
      reset_rtl_0_n = 1'b1;
      model_q.delete();
      repeat (2) @(negedge Clk);
   endtask

   initial begin
      test_reset();
      test_playback();
      test_volume();
      test_underrun();
      test_fifo_full();
      test_flush();
      test_pause();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
